// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared tetris types plus spi command-byte layout and decode helpers
package tetris_pkg;

  typedef enum logic [1:0] {
    CMD_LEFT   = 2'd0,
    CMD_RIGHT  = 2'd1,
    CMD_ROTATE = 2'd2,
    CMD_DROP   = 2'd3
  } command_t;

  typedef enum logic [2:0] {
    PIECE_I = 3'd0,
    PIECE_O = 3'd1,
    PIECE_T = 3'd2,
    PIECE_S = 3'd3,
    PIECE_Z = 3'd4,
    PIECE_J = 3'd5,
    PIECE_L = 3'd6
  } active_piece_t;

  typedef enum logic {
    CAP_IDLE,
    CAP_CLEAR
  } cap_state_t;

  localparam int MOVE_LSB       = 0;
  localparam int PIECE_LSB      = 2;
  localparam int MOVE_VALID_BIT = 5;

  typedef struct packed {
    command_t   move;
    logic       move_valid;
    logic [2:0] piece;
  } spi_cmd_t;

  // Index 7 has no piece behind it, so it folds onto the first piece.
  function automatic active_piece_t piece_from_index(logic [2:0] idx);
    return (idx == 3'd7) ? PIECE_I : active_piece_t'(idx);
  endfunction

  function automatic spi_cmd_t spi_cmd_from_byte(logic [5:0] b);
    spi_cmd_t c;
    c.move       = command_t'(b[MOVE_LSB +: 2]);
    c.move_valid = b[MOVE_VALID_BIT];
    c.piece      = piece_from_index(b[PIECE_LSB +: 3]);
    return c;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO; a push into a full FIFO is taken when a pop frees a slot
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             wdata_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/spi_command_queue.sv
// rtl/spi_command_queue.sv - captures spi bytes with a clear handshake and queues decoded commands for the game logic
import tetris_pkg::*;

module spi_command_queue #(
  parameter int DEPTH            = 4,
  parameter int DROP_COUNT_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [7:0]                   spi_data,
  input  logic                         spi_data_valid,
  output logic                         spi_clear,
  output logic                         cmd_valid,
  input  logic                         cmd_ready,
  output logic [1:0]                   cmd_move,
  output logic                         cmd_move_valid,
  output logic [2:0]                   cmd_piece,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic [DROP_COUNT_WIDTH-1:0]  drop_count,
  output logic                         overflow
);

  localparam int CMD_W = $bits(spi_cmd_t);

  cap_state_t                  state_q, state_d;
  logic                        spi_clear_q;
  logic [DROP_COUNT_WIDTH-1:0] drop_count_q, drop_count_d;
  logic                        overflow_q, overflow_d;
  logic                        push, pop, drop;
  logic                        fifo_full, fifo_empty;
  logic [CMD_W-1:0]            fifo_wdata, fifo_rdata;
  spi_cmd_t                    head;
  logic                        unused_byte_bits;

  // Top two bits of the command byte carry no meaning for the game.
  assign unused_byte_bits = ^spi_data[7:6];
  assign fifo_wdata       = spi_cmd_from_byte(spi_data[5:0]);

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      CAP_IDLE: begin
        if (spi_data_valid) begin
          push    = 1'b1;
          state_d = CAP_CLEAR;
        end
      end
      CAP_CLEAR: begin
        if (!spi_data_valid) state_d = CAP_IDLE;
      end
      default: state_d = CAP_IDLE;
    endcase
  end

  assign pop  = cmd_ready && !fifo_empty;
  assign drop = push && fifo_full && !pop;

  always_comb begin
    drop_count_d = drop_count_q;
    if (drop && (drop_count_q != '1)) drop_count_d = drop_count_q + 1'b1;
    overflow_d = overflow_q | drop;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= CAP_IDLE;
      spi_clear_q  <= 1'b0;
      drop_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      spi_clear_q  <= (state_d == CAP_CLEAR);
      drop_count_q <= drop_count_d;
      overflow_q   <= overflow_d;
    end
  end

  sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .wdata_i (fifo_wdata),
    .pop_i   (cmd_ready),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Stale storage must not leak onto the command fields while empty.
  assign head           = fifo_empty ? '0 : spi_cmd_t'(fifo_rdata);
  assign cmd_valid      = !fifo_empty;
  assign cmd_move       = head.move;
  assign cmd_move_valid = head.move_valid;
  assign cmd_piece      = head.piece;
  assign spi_clear      = spi_clear_q;
  assign drop_count     = drop_count_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_spi_command_queue.sv
// tb/tb_spi_command_queue.sv - directed scoreboard bench for spi_command_queue
module tb_spi_command_queue;

  localparam int DEPTH = 4;
  localparam int DCW   = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] spi_data;
  logic       spi_data_valid;
  logic       spi_clear;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_move;
  logic       cmd_move_valid;
  logic [2:0] cmd_piece;
  logic [2:0] fifo_count;
  logic [7:0] drop_count;
  logic       overflow;

  int vectors     = 0;
  int miscompares = 0;
  logic [5:0] exp_q[$];
  int model_count = 0;
  int model_drops = 0;

  always #5 clk = ~clk;

  spi_command_queue #(.DEPTH(DEPTH), .DROP_COUNT_WIDTH(DCW)) dut (
    .clk            (clk),
    .reset          (reset),
    .spi_data       (spi_data),
    .spi_data_valid (spi_data_valid),
    .spi_clear      (spi_clear),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_move       (cmd_move),
    .cmd_move_valid (cmd_move_valid),
    .cmd_piece      (cmd_piece),
    .fifo_count     (fifo_count),
    .drop_count     (drop_count),
    .overflow       (overflow)
  );

  function automatic logic [5:0] model_decode(logic [7:0] b);
    logic [2:0] p;
    p = b[4:2];
    if (p == 3'd7) p = 3'd0;
    return {b[1:0], b[5], p};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_push(logic [7:0] b, bit popping);
    if (model_count < DEPTH || popping) begin
      exp_q.push_back(model_decode(b));
      if (!popping) model_count++;
    end else if (model_drops < 255) begin
      model_drops++;
    end
  endtask

  task automatic send(logic [7:0] b, int hold);
    spi_data       = b;
    spi_data_valid = 1'b1;
    model_push(b, 1'b0);
    step(hold);
    spi_data_valid = 1'b0;
    step(1);
  endtask

  task automatic check_head(string tag);
    logic [5:0] e;
    chk({tag, "_valid"}, 32'(cmd_valid), 32'd1);
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_head"}, 32'({cmd_move, cmd_move_valid, cmd_piece}), 32'(e));
    end
    cmd_ready = 1'b1;
    step(1);
    cmd_ready = 1'b0;
    if (model_count > 0) model_count--;
  endtask

  task automatic model_reset();
    exp_q.delete();
    model_count = 0;
    model_drops = 0;
  endtask

  initial begin
    reset          = 1'b1;
    spi_data       = 8'h00;
    spi_data_valid = 1'b0;
    cmd_ready      = 1'b0;
    step(2);
    chk("rst_count",  32'(fifo_count), 32'd0);
    chk("rst_valid",  32'(cmd_valid),  32'd0);
    chk("rst_clear",  32'(spi_clear),  32'd0);
    chk("rst_drop",   32'(drop_count), 32'd0);
    chk("rst_ovf",    32'(overflow),   32'd0);
    chk("rst_fields", 32'({cmd_move, cmd_move_valid, cmd_piece}), 32'd0);
    reset = 1'b0;
    step(1);

    // First byte: latency, handshake and decode of 0x26.
    spi_data       = 8'h26;
    spi_data_valid = 1'b1;
    model_push(8'h26, 1'b0);
    step(1);
    chk("lat_valid", 32'(cmd_valid),      32'd1);
    chk("lat_clear", 32'(spi_clear),      32'd1);
    chk("lat_move",  32'(cmd_move),       32'd2);
    chk("lat_piece", 32'(cmd_piece),      32'd1);
    chk("lat_mv",    32'(cmd_move_valid), 32'd1);
    chk("lat_count", 32'(fifo_count),     32'd1);
    step(2);
    chk("hold_clear", 32'(spi_clear),  32'd1);
    chk("hold_count", 32'(fifo_count), 32'd1);
    spi_data_valid = 1'b0;
    step(1);
    chk("fall_clear", 32'(spi_clear), 32'd0);
    check_head("b26");
    chk("b26_empty", 32'(cmd_valid), 32'd0);

    // Overfill by one: fifth byte is dropped.
    send(8'h20, 1);
    send(8'h21, 1);
    send(8'h22, 1);
    send(8'h23, 1);
    send(8'h3C, 1);
    chk("ovf_count", 32'(fifo_count), 32'd4);
    chk("ovf_drop",  32'(drop_count), 32'(model_drops));
    chk("ovf_flag",  32'(overflow),   32'd1);
    for (int i = 0; i < 4; i++) check_head("drain5");
    chk("drain5_empty", 32'(cmd_valid), 32'd0);
    cmd_ready = 1'b1;
    step(1);
    cmd_ready = 1'b0;
    chk("ready_empty_count", 32'(fifo_count), 32'd0);

    // Piece index 7 clamps to 0.
    send(8'h1C, 1);
    check_head("b1C");

    // Full FIFO with simultaneous pop and push: no drop.
    send(8'h20, 1);
    send(8'h21, 1);
    send(8'h22, 1);
    send(8'h23, 1);
    chk("full_count", 32'(fifo_count), 32'd4);
    chk("full_head", 32'({cmd_move, cmd_move_valid, cmd_piece}), 32'(exp_q.pop_front()));
    spi_data       = 8'h01;
    spi_data_valid = 1'b1;
    cmd_ready      = 1'b1;
    model_push(8'h01, 1'b1);
    step(1);
    cmd_ready      = 1'b0;
    spi_data_valid = 1'b0;
    chk("pp_count", 32'(fifo_count), 32'd4);
    chk("pp_drop",  32'(drop_count), 32'(model_drops));
    step(1);
    for (int i = 0; i < 4; i++) check_head("drain_pp");

    // Long valid: one push only.
    send(8'h02, 20);
    chk("long_count", 32'(fifo_count), 32'd1);
    check_head("long");

    // Reset with three queued and the FSM in CLEAR.
    send(8'h21, 1);
    send(8'h22, 1);
    spi_data       = 8'h23;
    spi_data_valid = 1'b1;
    step(1);
    chk("pre_rst_count", 32'(fifo_count), 32'd3);
    chk("pre_rst_clear", 32'(spi_clear),  32'd1);
    reset          = 1'b1;
    spi_data_valid = 1'b0;
    step(1);
    model_reset();
    reset = 1'b0;
    chk("mid_rst_count", 32'(fifo_count), 32'd0);
    chk("mid_rst_valid", 32'(cmd_valid),  32'd0);
    chk("mid_rst_clear", 32'(spi_clear),  32'd0);
    chk("mid_rst_drop",  32'(drop_count), 32'd0);
    chk("mid_rst_ovf",   32'(overflow),   32'd0);

    // Valid still high when reset releases: byte captured.
    reset          = 1'b1;
    spi_data       = 8'h27;
    spi_data_valid = 1'b1;
    step(1);
    reset = 1'b0;
    model_push(8'h27, 1'b0);
    step(1);
    chk("post_rst_count", 32'(fifo_count), 32'd1);
    chk("post_rst_clear", 32'(spi_clear),  32'd1);
    spi_data_valid = 1'b0;
    step(1);
    check_head("post_rst");

    // Drop counter saturation.
    for (int i = 0; i < 4; i++) send(8'(8'h20 + i), 1);
    for (int i = 0; i < 300; i++) begin
      send(8'h3F, 1);
      if (i == 254) chk("drop_255", 32'(drop_count), 32'd255);
    end
    chk("sat_drop",  32'(drop_count), 32'(model_drops));
    chk("sat_value", 32'(drop_count), 32'd255);
    chk("sat_ovf",   32'(overflow),   32'd1);
    for (int i = 0; i < 4; i++) check_head("drain_sat");
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
